// File: rtl/alu_regfile_pipe_stim.sv
// rtl/alu_regfile_pipe_stim.sv - LFSR-driven pipelined ALU/register-file run engine with XOR signature
//
// An internal LFSR produces one pseudo-random ALU op per issue slot. Each op flows through
// decode (D), execute and writeback (W) stages against an NREG x XLEN register file.
// One start request runs exactly num_ops ops. Every committed result is folded into a
// rotating XOR signature.
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   start      one-cycle run request; only honoured in IDLE or DONE
//   num_ops    op count, captured on an accepted start
//   busy       high while running or draining
//   done       high once a run has completed, until the next start
//   result     last committed ALU result
//   signature  rotating XOR of all results committed in this run
//   retired    ops committed in this run (saturating)
//   cycles     cycles spent running or draining in this run (saturating)
//
// Build option ALU_STIM_BYPASS_EN: when defined, execute forwards the W result to D sources
// and never stalls. When undefined, a hazard holds D for one cycle and writes a bubble into W.
module alu_regfile_pipe_stim #(
    parameter int          XLEN = 32,
    parameter int          NREG = 8,
    parameter logic [31:0] SEED = 32'hDEADBEEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [15:0]     num_ops,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [XLEN-1:0] signature,
    output logic [15:0]     retired,
    output logic [31:0]     cycles
);
    localparam int AW = $clog2(NREG);
    localparam int SW = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            state_q,     state_d;
    logic [31:0]       lfsr_q,      lfsr_d;
    logic [15:0]       num_q,       num_d;
    logic [15:0]       issued_q,    issued_d;
    logic [15:0]       retired_q,   retired_d;
    logic [31:0]       cycles_q,    cycles_d;
    logic              d_valid_q,   d_valid_d;
    logic [2:0]        d_op_q,      d_op_d;
    logic [AW-1:0]     d_rd_q,      d_rd_d;
    logic [AW-1:0]     d_rs1_q,     d_rs1_d;
    logic [AW-1:0]     d_rs2_q,     d_rs2_d;
    logic [XLEN-1:0]   d_imm_q,     d_imm_d;
    logic              w_valid_q,   w_valid_d;
    logic [AW-1:0]     w_rd_q,      w_rd_d;
    logic [XLEN-1:0]   w_res_q,     w_res_d;
    logic [XLEN-1:0]   result_q,    result_d;
    logic [XLEN-1:0]   signature_q, signature_d;
    logic [XLEN-1:0]   regfile_q [NREG];
    logic [XLEN-1:0]   regfile_d [NREG];

    logic [31:0]       lfsr_next;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   src1, src2, alu_res;
    logic              stall, issue;

    always_comb begin
        lfsr_next = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
        // LFSR word repeated to fill wide datapaths, truncated for narrow ones
        imm = '0;
        for (int i = 0; i < XLEN; i++) begin
            imm[i] = lfsr_q[i % 32];
        end

        src1 = regfile_q[d_rs1_q];
        src2 = regfile_q[d_rs2_q];
`ifdef ALU_STIM_BYPASS_EN
        stall = 1'b0;
        if (w_valid_q && (d_rs1_q == w_rd_q)) src1 = w_res_q;
        if (w_valid_q && (d_rs2_q == w_rd_q)) src2 = w_res_q;
`else
        // W commits into the regfile on the coming edge; D must wait for it
        stall = d_valid_q && w_valid_q && ((d_rs1_q == w_rd_q) || (d_rs2_q == w_rd_q));
`endif

        alu_res = '0;
        case (d_op_q)
            3'd0:    alu_res = src1 + src2;
            3'd1:    alu_res = src1 - src2;
            3'd2:    alu_res = src1 & src2;
            3'd3:    alu_res = src1 | src2;
            3'd4:    alu_res = src1 ^ src2;
            3'd5:    alu_res = src1 << src2[SW-1:0];
            3'd6:    alu_res = src1 >> src2[SW-1:0];
            default: alu_res = d_imm_q;
        endcase

        state_d     = state_q;
        lfsr_d      = lfsr_q;
        num_d       = num_q;
        issued_d    = issued_q;
        retired_d   = retired_q;
        cycles_d    = cycles_q;
        d_valid_d   = d_valid_q;
        d_op_d      = d_op_q;
        d_rd_d      = d_rd_q;
        d_rs1_d     = d_rs1_q;
        d_rs2_d     = d_rs2_q;
        d_imm_d     = d_imm_q;
        result_d    = result_q;
        signature_d = signature_q;
        regfile_d   = regfile_q;

        // Commit
        if (w_valid_q) begin
            regfile_d[w_rd_q] = w_res_q;
            result_d          = w_res_q;
            signature_d       = {signature_q[XLEN-2:0], signature_q[XLEN-1]} ^ w_res_q;
            if (retired_q != 16'hFFFF) retired_d = retired_q + 16'd1;
        end

        // Execute into W; a stall leaves a bubble behind
        w_valid_d = d_valid_q && !stall;
        w_rd_d    = d_rd_q;
        w_res_d   = alu_res;

        // Issue into D
        issue = (state_q == S_RUN) && !stall;
        if (issue) begin
            d_valid_d = 1'b1;
            d_op_d    = lfsr_q[2:0];
            d_rd_d    = lfsr_q[3 +: AW];
            d_rs1_d   = lfsr_q[3 + AW +: AW];
            d_rs2_d   = lfsr_q[3 + 2 * AW +: AW];
            d_imm_d   = imm;
            lfsr_d    = lfsr_next;
            issued_d  = issued_q + 16'd1;
        end else if (!stall) begin
            d_valid_d = 1'b0;
        end

        if (((state_q == S_RUN) || (state_q == S_DRAIN)) && (cycles_q != 32'hFFFF_FFFF)) begin
            cycles_d = cycles_q + 32'd1;
        end

        case (state_q)
            S_RUN: begin
                if (issue && ((issued_q + 16'd1) == num_q)) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (retired_q == num_q) state_d = S_DONE;
            end
            default: begin
                if (start) begin
                    state_d     = (num_ops == 16'd0) ? S_DONE : S_RUN;
                    num_d       = num_ops;
                    lfsr_d      = SEED;
                    issued_d    = '0;
                    retired_d   = '0;
                    cycles_d    = '0;
                    signature_d = '0;
                    regfile_d   = '{default: '0};
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            lfsr_q      <= SEED;
            num_q       <= '0;
            issued_q    <= '0;
            retired_q   <= '0;
            cycles_q    <= '0;
            d_valid_q   <= 1'b0;
            d_op_q      <= '0;
            d_rd_q      <= '0;
            d_rs1_q     <= '0;
            d_rs2_q     <= '0;
            d_imm_q     <= '0;
            w_valid_q   <= 1'b0;
            w_rd_q      <= '0;
            w_res_q     <= '0;
            result_q    <= '0;
            signature_q <= '0;
            regfile_q   <= '{default: '0};
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            num_q       <= num_d;
            issued_q    <= issued_d;
            retired_q   <= retired_d;
            cycles_q    <= cycles_d;
            d_valid_q   <= d_valid_d;
            d_op_q      <= d_op_d;
            d_rd_q      <= d_rd_d;
            d_rs1_q     <= d_rs1_d;
            d_rs2_q     <= d_rs2_d;
            d_imm_q     <= d_imm_d;
            w_valid_q   <= w_valid_d;
            w_rd_q      <= w_rd_d;
            w_res_q     <= w_res_d;
            result_q    <= result_d;
            signature_q <= signature_d;
            regfile_q   <= regfile_d;
        end
    end

    assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);
    assign result    = result_q;
    assign signature = signature_q;
    assign retired   = retired_q;
    assign cycles    = cycles_q;
endmodule

// File: doc/alu_regfile_pipe_stim.md
Name: alu_regfile_pipe_stim

Overview:
Parametrised, pipelined successor to the single-stage self-stimulus ALU/register-file benchmark block.
- An internal LFSR generates one pseudo-random ALU op per issue slot. The op runs through a decode/execute/commit pipeline against an NREG x XLEN register file.
- A run controller executes exactly num_ops operations per start request.
- Results fold into a rotating XOR signature, so benches and simulator regressions compare one number per run.

Parameters:
XLEN, 32, datapath/register width; legal 8, 16, 32, 64
NREG, 8, register count; power of two, 2..16; AW = $clog2(NREG)
SEED, 32'hDEADBEEF, LFSR reload value; must be nonzero

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  one-cycle run request; honoured only in IDLE or DONE
num_ops  input  16  op count, sampled on the accepted start
busy  output  1  high in RUN and DRAIN
done  output  1  high in DONE
result  output  XLEN  last committed ALU result
signature  output  XLEN  rotating XOR of all committed results this run
retired  output  16  ops committed this run
cycles  output  32  clock cycles spent in RUN and DRAIN this run

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; lfsr=SEED; regfile, D/W valids, result, signature, retired, cycles = 0; busy=done=0. Reset mid-run aborts immediately and leaves no residue.
- LFSR: 32-bit; next = {lfsr[30:0], lfsr[31]^lfsr[21]^lfsr[1]^lfsr[0]}. Advances only on an issue.
- Decode fields from current lfsr:
  - op=lfsr[2:0]
  - rd=lfsr[3+:AW], rs1=lfsr[3+AW+:AW], rs2=lfsr[3+2AW+:AW]
  - imm=lfsr replicated and truncated to XLEN
- FSM:
  - IDLE/DONE + start -> RUN. On entry: capture num_ops; lfsr=SEED; regfile, signature, retired, cycles cleared.
  - If num_ops==0: -> DONE instead; counters stay 0.
  - RUN: one issue per cycle unless stalled. Issue latches fields into D, sets D valid, advances lfsr, increments issued count. After the num_ops-th issue -> DRAIN.
  - DRAIN -> DONE on the edge after retired==num_ops.
  - DONE holds outputs until the next start.
  - start in RUN/DRAIN is ignored.
- Pipeline:
  - D register: decoded fields.
  - Execute is combinational from D and writes the W register (w_res, w_rd, w_valid).
  - Commit on the edge after W valid: regfile[w_rd]<=w_res; result<=w_res; signature<={signature[XLEN-2:0],signature[XLEN-1]}^w_res; retired+1.
- ALU, modulo 2^XLEN:
  - 0 add, 1 sub, 2 and, 3 or, 4 xor
  - 5 sll and 6 srl by src2[$clog2(XLEN)-1:0]
  - 7 imm
- Hazard: D reads rs1 or rs2 equal to w_rd while w_valid. Resolution per the Optional Feature. Committed results and signature are identical either way.
- cycles increments every cycle in RUN or DRAIN; retired and cycles saturate at max.
- Latency, num_ops=1, no stall:
  - start edge k -> RUN
  - k+1: D valid
  - k+2: W valid
  - k+3: commit
  - k+4: DONE
  - cycles=4

Optional Feature:
Macro ALU_STIM_BYPASS_EN.
- Defined: execute takes w_res for any source register matching w_rd while w_valid. Never stalls; cycles = num_ops+3 for num_ops>0.
- Undefined: interlock. On a hazard, D is held, a bubble is written into W, and lfsr and the issued count freeze for one cycle. The op re-executes after commit, so cycles = num_ops+3+stall count.

Test Plan:
1. Defaults, start with num_ops=1 -> first op is imm (op=7, rd=5): regfile[5]=result=signature=32'hDEADBEEF, retired=1, done at k+4, cycles=4.
2. start with num_ops=0 -> DONE next edge, signature=0, retired=0, cycles=0, busy never high.
3. num_ops=1000, both macro builds vs a C/Python reference model of the same LFSR/ALU -> identical signature and retired=1000. Bypass build cycles=1003; interlock build cycles=1003+stalls, with stalls>0 checked.
4. rst_n low for one cycle at retired=37 -> all outputs 0 and IDLE asynchronously. A following start with num_ops=100 -> signature equals a clean 100-op run.
5. start pulsed during RUN and DRAIN -> ignored, run count unchanged. start in DONE with same num_ops -> bit-identical signature.
6. XLEN=16, NREG=4, num_ops=500 -> shifts use 4-bit amount, imm=lfsr[15:0], rd uses lfsr[4:3]; signature matches the reference model.
